interval_timer_ctrl: RTL
========================

Name: interval_timer_ctrl

Overview:
Programmable interval-timer controller built around a mod-PRESCALE prescaler and a CW-bit down-counter. It sequences start, stop, pause and one-shot or auto-reload operation, and signals expiry with a single-cycle done pulse. Peripherals use it to schedule periodic events from a single clock.

Parameters:
PRESCALE, 10, prescaler modulus; one prescaler tick every PRESCALE enabled clocks (must be >= 2)
PW, $clog2(PRESCALE), prescaler count width
CW, 16, period and remaining-count width

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-high reset
start  in  1  single-cycle request: latch period and mode, then (re)start
stop  in  1  abort and return to idle
pause  in  1  level input; freezes counting while high
auto_reload  in  1  sampled at start: 1 = periodic, 0 = one-shot
period  in  CW  number of prescaler ticks per interval, sampled at start
busy  out  1  state != IDLE
paused  out  1  state == PAUSE
pre_tick  out  1  combinational; advance && (pre == PRESCALE-1)
done  out  1  registered single-cycle expiry pulse
cfg_err  out  1  registered single-cycle pulse when start is rejected
remain  out  CW  current down-counter value
pre_q  out  PW  current prescaler value

Behaviour:
- Reset (asynchronous, any time, including mid-run): state = IDLE; pre = 0; cnt = 0; period_l = 0; mode_l = 0; done = 0; cfg_err = 0. All outputs read 0.
- States: IDLE, RUN, PAUSE. Priority per cycle: stop > start > pause > counting.
- stop in any state: next state IDLE, pre = 0, cnt = 0, no done. stop wins over a simultaneous start or expiry.
- start with period != 0, in any state:
  - period_l = period, mode_l = auto_reload, cnt = period-1, pre = 0, next state RUN.
  - This restarts a running timer. A simultaneous expiry is discarded (no done).
- start with period == 0: state and counters are unchanged and cfg_err pulses for 1 cycle.
- advance = (state == RUN) && !pause && !start && !stop. pre increments only when advance is high and wraps PRESCALE-1 -> 0.
- Tick event = advance && pre == PRESCALE-1.
  - On a tick with cnt != 0: cnt decrements.
  - On a tick with cnt == 0 (expiry): done = 1 for the next cycle.
    - One-shot (mode_l = 0): next state IDLE.
    - Periodic (mode_l = 1): cnt = period_l-1 and state stays RUN; pre wraps to 0 seamlessly.
- Latency: done is high in the cycle after clock edge (t + P*PRESCALE), where t is the edge that sampled start and P = period. The periodic interval is exactly P*PRESCALE clocks.
- Pause:
  - RUN with pause high -> PAUSE; PAUSE with pause low -> RUN.
  - While in PAUSE, pre and cnt hold.
  - A pause held high for N cycles delays expiry by N+1 cycles. No expiry can occur while pause is high.
- period changes while running have no effect until the next start.
- Inputs in IDLE other than start are ignored. pause in IDLE does not enter PAUSE.

Optional Feature:
- Macro: INTERVAL_TIMER_CTRL_IRQ_EN.
- Defined:
  - Adds input irq_clr (1 bit) and output irq (1 bit, registered, reset 0).
  - irq is set on every done and stays set until irq_clr is high.
  - If done and irq_clr coincide, set wins.
  - Also adds output ovr (1 bit, sticky): set when done occurs while irq is already 1; cleared by irq_clr, with set winning on coincidence.
- Undefined: irq_clr, irq and ovr ports do not exist; all other behaviour is identical.

Test Plan:
- Reset mid-RUN (PRESCALE=10, period=3) -> all outputs 0 immediately; no done afterwards without a new start.
- One-shot: start with period=3, auto_reload=0 -> done exactly 30 clocks after the start edge, pulse width 1; busy falls the same edge; remain sequence 2,1,0.
- Periodic: start with period=2, auto_reload=1 -> done at clocks 20, 40 and 60 after start; stop at clock 45 -> busy=0, no done at 60.
- Pause: period=1, pause high for 4 cycles starting at clock 5 -> done at clock 15 (10+4+1); paused high for 4 cycles.
- Collisions:
  - start with period=0 -> cfg_err single pulse, busy unchanged.
  - stop coincident with an expiry tick -> no done.
  - start coincident with an expiry tick -> no done; new interval counted from that start.
- With INTERVAL_TIMER_CTRL_IRQ_EN, two expiries without irq_clr -> irq=1, ovr=1; irq_clr pulse -> both 0 next cycle; irq_clr on a done cycle -> irq remains 1.

Source files
------------

// File: rtl/interval_timer_ctrl.sv
// Programmable interval timer: a mod-PRESCALE prescaler drives a CW-bit down-counter.
// It supports one-shot and periodic modes, pause, and stop. Define INTERVAL_TIMER_CTRL_IRQ_EN to add a sticky irq/ovr pair.
module interval_timer_ctrl #(
  parameter int PRESCALE = 10,
  parameter int PW       = $clog2(PRESCALE),
  parameter int CW       = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          stop,
  input  logic          pause,
  input  logic          auto_reload,
  input  logic [CW-1:0] period,
`ifdef INTERVAL_TIMER_CTRL_IRQ_EN
  input  logic          irq_clr,
  output logic          irq,
  output logic          ovr,
`endif
  output logic          busy,
  output logic          paused,
  output logic          pre_tick,
  output logic          done,
  output logic          cfg_err,
  output logic [CW-1:0] remain,
  output logic [PW-1:0] pre_q
);

  typedef enum logic [1:0] {IDLE, RUN, PAUSE} state_e;

  localparam logic [PW-1:0] PRE_LAST = PW'(PRESCALE - 1);

  state_e        state_q;
  logic [CW-1:0] cnt_q;
  logic [CW-1:0] period_q;
  logic          mode_q;
  logic          done_q;
  logic          cfg_err_q;

  logic advance;
  logic pre_wrap;

  // Any start or stop in the same cycle steals the counting slot.
  assign advance  = (state_q == RUN) && !pause && !start && !stop;
  assign pre_wrap = (pre_q == PRE_LAST);
  assign pre_tick = advance && pre_wrap;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      pre_q     <= '0;
      cnt_q     <= '0;
      period_q  <= '0;
      mode_q    <= 1'b0;
      done_q    <= 1'b0;
      cfg_err_q <= 1'b0;
    end else begin
      done_q    <= 1'b0;
      cfg_err_q <= 1'b0;
      if (stop) begin
        state_q <= IDLE;
        pre_q   <= '0;
        cnt_q   <= '0;
      end else if (start) begin
        if (period != '0) begin
          period_q <= period;
          mode_q   <= auto_reload;
          cnt_q    <= period - CW'(1);
          pre_q    <= '0;
          state_q  <= RUN;
        end else begin
          cfg_err_q <= 1'b1;
        end
      end else begin
        case (state_q)
          RUN: begin
            if (pause) begin
              state_q <= PAUSE;
            end else begin
              pre_q <= pre_wrap ? '0 : pre_q + PW'(1);
              if (pre_wrap) begin
                if (cnt_q != '0) begin
                  cnt_q <= cnt_q - CW'(1);
                end else begin
                  // Expiry: periodic reloads without losing a clock, one-shot parks in IDLE.
                  done_q <= 1'b1;
                  if (mode_q) cnt_q <= period_q - CW'(1);
                  else        state_q <= IDLE;
                end
              end
            end
          end
          PAUSE: begin
            if (!pause) state_q <= RUN;
          end
          default: ;
        endcase
      end
    end
  end

  assign busy    = (state_q != IDLE);
  assign paused  = (state_q == PAUSE);
  assign done    = done_q;
  assign cfg_err = cfg_err_q;
  assign remain  = cnt_q;

`ifdef INTERVAL_TIMER_CTRL_IRQ_EN
  logic irq_q;
  logic ovr_q;

  // A done arriving together with irq_clr keeps irq set.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      irq_q <= 1'b0;
      ovr_q <= 1'b0;
    end else begin
      irq_q <= done_q | (irq_q & ~irq_clr);
      ovr_q <= (done_q & irq_q) | (ovr_q & ~irq_clr);
    end
  end

  assign irq = irq_q;
  assign ovr = ovr_q;
`endif

endmodule
